// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and the single-cycle ALU function
// shared by alu_seq and alu_seq_shiftmul.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_PSA = 4'h8;
    localparam logic [3:0] OP_PSB = 4'h9;
    localparam logic [3:0] OP_NEG = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_SHL = 4'hC;
    localparam logic [3:0] OP_SHR = 4'hD;
    localparam logic [3:0] OP_ASR = 4'hE;
    localparam logic [3:0] OP_MUL = 4'hF;

    // Widest datapath the single-cycle function supports.
    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [MAXW-1:0] c;
        logic            cout;
        logic            ovf;
    } alu_res_t;

    // Operands arrive zero-extended to MAXW; w is the live width.
    // Sign and carry bits are picked with masks so that w may be
    // any constant up to MAXW. Shifts and mul return pass-a, which
    // is the correct result for a zero shift or a disabled mul.
    function automatic alu_res_t alu_single(
        input logic [3:0]      op,
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input logic            cin,
        input int unsigned     w
    );
        alu_res_t      r;
        logic [MAXW:0] s;
        logic [MAXW:0] ea;
        logic [MAXW:0] eb;
        logic [MAXW:0] ec;
        logic [MAXW:0] cm;
        logic [MAXW:0] msk;
        logic [MAXW:0] mb;
        logic          sa;
        logic          sb;
        logic          sr;
        r   = '0;
        ea  = {1'b0, a};
        eb  = {1'b0, b};
        ec  = {{MAXW{1'b0}}, cin};
        cm  = (MAXW+1)'(1) << w;
        msk = cm - (MAXW+1)'(1);
        mb  = (MAXW+1)'(1) << (w - 1);
        case (op)
            OP_ADD:  s = ea + eb;
            OP_ADC:  s = ea + eb + ec;
            OP_SUB:  s = ea - eb;
            OP_SBC:  s = ea - eb - ec;
            OP_OR:   s = ea | eb;
            OP_AND:  s = ea & eb;
            OP_NOT:  s = ~ea;
            OP_XOR:  s = ea ^ eb;
            OP_PSB:  s = eb;
            OP_NEG:  s = '0 - ea;
            OP_CMP:  s = (a < b) ? msk :
                         (a == b) ? '0 : (MAXW+1)'(1);
            default: s = ea;
        endcase
        sa = |(ea & mb);
        sb = |(eb & mb);
        sr = |(s & mb);
        case (op)
            OP_ADD, OP_ADC: begin
                r.cout = |(s & cm);
                r.ovf  = (sa == sb) && (sr != sa);
            end
            OP_SUB, OP_SBC: begin
                r.cout = |(s & cm);
                r.ovf  = (sa != sb) && (sr != sa);
            end
            OP_NEG: begin
                r.cout = |a;
                r.ovf  = (ea == mb);
            end
            OP_CMP:  r.cout = (a < b);
            default: ;
        endcase
        r.c = MAXW'(s & msk);
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_shiftmul.sv
// alu_seq_shiftmul: iterative datapath for shl/shr/asr and, with
// ALU_SEQ_MUL_EN defined, an unsigned shift-add multiplier.
// Ports: load captures op/a/b; step advances one bit; busy means
// more steps remain after this one; nxt_* is the post-step result.
module alu_seq_shiftmul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] nxt_lo,
    output logic [WIDTH-1:0] nxt_hi,
    output logic             nxt_co
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [3:0]       op_q;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_n;
    logic             co;
    logic             co_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_ld;
    logic             adv;

    assign adv  = step && (cnt != '0);
    assign busy = (cnt > CW'(1));

    always_comb begin
        sh_n = sh;
        co_n = co;
        case (op_q)
            OP_SHL: begin
                sh_n = {sh[WIDTH-2:0], 1'b0};
                co_n = sh[WIDTH-1];
            end
            OP_SHR: begin
                sh_n = {1'b0, sh[WIDTH-1:1]};
                co_n = sh[0];
            end
            OP_ASR: begin
                sh_n = {sh[WIDTH-1], sh[WIDTH-1:1]};
                co_n = sh[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     psum;
    logic               is_mul;

    // Multiplier sits in acc[WIDTH-1:0]; each step adds the
    // multiplicand to the top half on its LSB, then shifts right.
    always_comb begin
        psum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, mcand} : '0);
        acc_n = {psum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, b};
            mcand <= a;
        end else if (adv) begin
            acc   <= acc_n;
        end
    end

    assign is_mul = (op_q == OP_MUL);
    assign cnt_ld = (op == OP_MUL) ? CW'(WIDTH)
                                   : CW'(b[SHW-1:0]);
    assign nxt_lo = is_mul ? acc_n[WIDTH-1:0] : sh_n;
    assign nxt_hi = is_mul ? acc_n[2*WIDTH-1:WIDTH] : '0;
    assign nxt_co = is_mul ? |acc_n[2*WIDTH-1:WIDTH] : co_n;
`else
    logic unused_b;

    assign unused_b = ^b;
    assign cnt_ld   = CW'(b[SHW-1:0]);
    assign nxt_lo   = sh_n;
    assign nxt_hi   = '0;
    assign nxt_co   = co_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OP_ADD;
            sh   <= '0;
            co   <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            op_q <= op;
            sh   <= a;
            co   <= 1'b0;
            cnt  <= cnt_ld;
        end else if (adv) begin
            sh   <= sh_n;
            co   <= co_n;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready in and out, registered flags,
// iterative shifts and optional multiplier (macro ALU_SEQ_MUL_EN).
// Ports: in_valid/in_ready + a/b/carry/op in; out_valid/out_ready +
// c/c_hi/carry_out/zero/negative/overflow out. Async active-high rst.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    state_t           state;
    alu_res_t         res;
    logic [WIDTH-1:0] sc_c;
    logic             unused_res;
    logic             is_shift;
    logic             is_mul;
    logic             multi;
    logic             load;
    logic             step;
    logic             busy;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic             nxt_co;

    assign res = alu_single(op, MAXW'(a), MAXW'(b), carry, WIDTH);
    assign sc_c       = res.c[WIDTH-1:0];
    assign unused_res = ^res.c;

    assign is_shift = (op == OP_SHL) || (op == OP_SHR)
                   || (op == OP_ASR);
`ifdef ALU_SEQ_MUL_EN
    assign is_mul = (op == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif
    // A zero shift amount is just pass-a, done in one cycle.
    assign multi = is_mul || (is_shift && (b[SHW-1:0] != '0));

    assign in_ready = (state == ST_IDLE);
    assign load     = in_ready && in_valid && multi;
    assign step     = (state == ST_EXEC);

    alu_seq_shiftmul #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shiftmul (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .nxt_lo (nxt_lo),
        .nxt_hi (nxt_hi),
        .nxt_co (nxt_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            c         <= '0;
            c_hi      <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && multi) begin
                        state <= ST_EXEC;
                    end else if (in_valid) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        c         <= sc_c;
                        c_hi      <= '0;
                        carry_out <= res.cout;
                        zero      <= (sc_c == '0);
                        negative  <= sc_c[WIDTH-1];
                        overflow  <= res.ovf;
                    end
                end
                ST_EXEC: begin
                    // Final step's result is captured directly.
                    if (!busy) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        c         <= nxt_lo;
                        c_hi      <= nxt_hi;
                        carry_out <= nxt_co;
                        zero      <= (nxt_lo == '0);
                        negative  <= nxt_lo[WIDTH-1];
                        overflow  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// Works with or without ALU_SEQ_MUL_EN defined.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
    logic [7:0] c_hi;
    logic       carry_out;
    logic       zero;
    logic       negative;
    logic       overflow;

    int checks = 0;
    int passes = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry     (carry),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_hi      (c_hi),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op, return cycles from accept to out_valid (1 =
    // visible right after the accepting edge). Capped at 40.
    task automatic run_op(input logic [3:0] o, input logic [7:0] xa,
                          input logic [7:0] xb, input logic ci,
                          output int lat);
        int g;
        g = 0;
        while (!in_ready && g < 40) begin
            @(posedge clk); #1; g++;
        end
        op = o; a = xa; b = xb; carry = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; carry = 1'b0; op = OP_ADD;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hs got ov=%b ir=%b want 0 1",
                     out_valid, in_ready);
        else passes++;
        checks++;
        if ({c, c_hi, carry_out, zero, negative, overflow} !== '0)
            $display("FAIL reset_out got c=%h hi=%h f=%b%b%b%b want 0",
                     c, c_hi, carry_out, zero, negative, overflow);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        int lat;
        run_op(OP_ADD, 8'h7F, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 1 || c !== 8'h80)
            $display("FAIL add_c got lat=%0d c=%h want 1 80", lat, c);
        else passes++;
        checks++;
        if ({overflow, negative, carry_out, zero} !== 4'b1100)
            $display("FAIL add_flags got %b want 1100",
                     {overflow, negative, carry_out, zero});
        else passes++;
        release_out();
        run_op(OP_SBC, 8'h00, 8'h00, 1'b1, lat);
        checks++;
        if (c !== 8'hFF || carry_out !== 1'b1 || overflow !== 1'b0)
            $display("FAIL sbc got c=%h co=%b ov=%b want ff 1 0",
                     c, carry_out, overflow);
        else passes++;
        release_out();
        run_op(OP_ADD, 8'hFF, 8'h01, 1'b0, lat);
        checks++;
        if ({c, carry_out, zero, overflow} !== {8'h00, 3'b110})
            $display("FAIL add_wrap got c=%h co=%b z=%b ov=%b",
                     c, carry_out, zero, overflow);
        else passes++;
        release_out();
        run_op(OP_SUB, 8'h80, 8'h01, 1'b0, lat);
        checks++;
        if ({c, carry_out, overflow} !== {8'h7F, 2'b01})
            $display("FAIL sub_ovf got c=%h co=%b ov=%b want 7f 0 1",
                     c, carry_out, overflow);
        else passes++;
        release_out();
        run_op(OP_NEG, 8'h80, 8'h00, 1'b0, lat);
        checks++;
        if ({c, carry_out, overflow} !== {8'h80, 2'b11})
            $display("FAIL neg got c=%h co=%b ov=%b want 80 1 1",
                     c, carry_out, overflow);
        else passes++;
        release_out();
    endtask

    task automatic test_logic();
        int lat;
        run_op(OP_XOR, 8'hF0, 8'h3C, 1'b1, lat);
        checks++;
        if (c !== 8'hCC || carry_out !== 1'b0)
            $display("FAIL xor got c=%h co=%b want cc 0", c, carry_out);
        else passes++;
        release_out();
        run_op(OP_NOT, 8'h0F, 8'h00, 1'b0, lat);
        checks++;
        if (c !== 8'hF0 || negative !== 1'b1)
            $display("FAIL not got c=%h n=%b want f0 1", c, negative);
        else passes++;
        release_out();
    endtask

    task automatic test_cmp();
        int lat;
        run_op(OP_CMP, 8'h10, 8'h20, 1'b0, lat);
        checks++;
        if (c !== 8'hFF || carry_out !== 1'b1)
            $display("FAIL cmp_lt got c=%h co=%b want ff 1", c, carry_out);
        else passes++;
        release_out();
        run_op(OP_CMP, 8'h33, 8'h33, 1'b0, lat);
        checks++;
        if (c !== 8'h00 || zero !== 1'b1)
            $display("FAIL cmp_eq got c=%h z=%b want 00 1", c, zero);
        else passes++;
        release_out();
        run_op(OP_CMP, 8'h21, 8'h20, 1'b0, lat);
        checks++;
        if (c !== 8'h01 || carry_out !== 1'b0)
            $display("FAIL cmp_gt got c=%h co=%b want 01 0", c, carry_out);
        else passes++;
        release_out();
    endtask

    task automatic test_shift();
        int lat;
        run_op(OP_SHR, 8'h81, 8'h03, 1'b0, lat);
        checks++;
        if (lat !== 4 || c !== 8'h10 || carry_out !== 1'b0)
            $display("FAIL shr got lat=%0d c=%h co=%b want 4 10 0",
                     lat, c, carry_out);
        else passes++;
        release_out();
        run_op(OP_ASR, 8'h80, 8'h07, 1'b0, lat);
        checks++;
        if (lat !== 8 || c !== 8'hFF || carry_out !== 1'b0)
            $display("FAIL asr got lat=%0d c=%h co=%b want 8 ff 0",
                     lat, c, carry_out);
        else passes++;
        release_out();
        run_op(OP_SHL, 8'hC0, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 1 || c !== 8'hC0 || carry_out !== 1'b0)
            $display("FAIL shl0 got lat=%0d c=%h co=%b want 1 c0 0",
                     lat, c, carry_out);
        else passes++;
        release_out();
        run_op(OP_SHL, 8'h81, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 2 || c !== 8'h02 || carry_out !== 1'b1)
            $display("FAIL shl1 got lat=%0d c=%h co=%b want 2 02 1",
                     lat, c, carry_out);
        else passes++;
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(OP_ADD, 8'h01, 8'h02, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                c !== 8'h03 || zero !== 1'b0 || carry_out !== 1'b0)
                $display("FAIL hold%0d got ov=%b ir=%b c=%h want 1 0 03",
                         i, out_valid, in_ready, c);
            else passes++;
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL release got ov=%b ir=%b want 0 1",
                     out_valid, in_ready);
        else passes++;
        run_op(OP_PSB, 8'h11, 8'h5A, 1'b0, lat);
        checks++;
        if (lat !== 1 || c !== 8'h5A)
            $display("FAIL second_op got lat=%0d c=%h want 1 5a", lat, c);
        else passes++;
        release_out();
    endtask

    task automatic test_reset_mid();
        logic seen;
        op = OP_SHL; a = 8'hFF; b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (c !== 8'h00 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_mid got c=%h ir=%b ov=%b want 00 1 0",
                     c, in_ready, out_valid);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0)
            $display("FAIL rst_drop got out_valid seen=%b want 0", seen);
        else passes++;
    endtask

    task automatic test_mul();
        int lat;
        run_op(OP_MUL, 8'hFF, 8'hFF, 1'b0, lat);
`ifdef ALU_SEQ_MUL_EN
        checks++;
        if (lat !== 9 || {c_hi, c} !== 16'hFE01 || carry_out !== 1'b1)
            $display("FAIL mul got lat=%0d p=%h co=%b want 9 fe01 1",
                     lat, {c_hi, c}, carry_out);
        else passes++;
`else
        checks++;
        if (lat !== 1 || c !== 8'hFF || c_hi !== 8'h00 ||
            carry_out !== 1'b0 || negative !== 1'b1)
            $display("FAIL mul_off got lat=%0d c=%h hi=%h co=%b n=%b",
                     lat, c, c_hi, carry_out, negative);
        else passes++;
`endif
        release_out();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_cmp();
        test_shift();
        test_back_to_back();
        test_reset_mid();
        test_mul();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the 8-bit combinational ALU.
- Adds the following over the combinational version:
  - registered results and flags, including the missing signed-overflow and negative flags;
  - a valid/ready handshake;
  - multi-cycle barrel-free shift ops;
  - an optional multi-cycle shift-add multiplier.
- Sits between the register file and the writeback stage of the CPU datapath.

Parameters:
- WIDTH, 8: operand/result width in bits (≥4).
- SHW, $clog2(WIDTH): width of the shift-amount field taken from b.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shift amount is b[SHW-1:0].
- carry  in  1  carry/borrow in for adc/sbc.
- op  in  4  opcode (see Behaviour).
- out_valid  out  1  result/flags valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- c  out  WIDTH  result.
- c_hi  out  WIDTH  upper half of the product for mul; 0 for all other ops.
- carry_out  out  1  carry / borrow / shifted-out bit.
- zero  out  1  c == 0.
- negative  out  1  c[WIDTH-1].
- overflow  out  1  signed overflow (add/adc/sub/sbc/neg only, else 0).

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; c, c_hi, carry_out, zero, negative, overflow all 0. Reset mid-operation aborts it and drops the result.
- Operands are captured on an in_valid && in_ready edge. Inputs are don't-care at all other times.
- Opcodes (all arithmetic done in WIDTH+1 bits):
  - 0 add: a+b.
  - 1 adc: a+b+carry.
  - 2 sub: a-b; carry_out=borrow.
  - 3 sbc: a-b-carry.
  - 4 or, 5 and, 6 not a, 7 xor: carry_out=0.
  - 8 pass a, 9 pass b.
  - A neg: 0-a; carry_out=(a!=0); overflow=(a==MSB-only).
  - B cmp (unsigned):
    - a<b gives all-ones with carry_out=1;
    - a==b gives 0;
    - a>b gives 1.
  - C shl, D shr (logical), E asr.
  - F mul: only when the optional feature is enabled; otherwise pass a.
- Overflow for add/sub: set on sign(a)==sign(±b) && sign(c)!=sign(a).
- FSM: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: accept the op. Single-cycle ops (0-B) compute in this cycle and go straight to DONE. Result and out_valid are registered on the next edge, so latency is 1.
  - EXEC, shifts:
    - A down-counter is loaded with n=b[SHW-1:0]; one bit is shifted per cycle.
    - carry_out = the last bit shifted out.
    - n=0 skips EXEC (latency 1, c=a, carry_out=0).
    - Latency = n+1.
  - EXEC, mul:
    - WIDTH iterations of shift-add over 2*WIDTH bits; latency WIDTH+1.
    - {c_hi,c} = unsigned product.
    - carry_out = (c_hi!=0).
    - zero refers to the low half only.
  - DONE: out_valid=1 and outputs held stable until out_ready. On out_valid && out_ready, go to IDLE; out_valid falls on the next edge.
- in_ready is 0 in EXEC and DONE; there is no overlap and no input buffering.
- A new op can be accepted in the cycle after the DONE handshake, giving a back-to-back throughput of one op per 2 cycles.
- Wrap-around: add/sub results wrap modulo 2^WIDTH; the carry/borrow goes to carry_out.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op F is the unsigned multiplier described above, with the 2*WIDTH accumulator and iteration counter.
- Undefined: op F behaves as pass a (latency 1, c_hi=0, all flags from a); no multiplier logic is synthesised.

Decomposition:
- Package alu_seq_pkg:
  - opcode constants OP_ADD..OP_MUL (4-bit);
  - FSM state enum {ST_IDLE, ST_EXEC, ST_DONE};
  - a function computing single-cycle result/flags for a given WIDTH.
- One natural sub-module: alu_seq_shiftmul. It holds the iterative datapath (shift register, counter, accumulator), is controlled by the top FSM via load/step/busy, and its mul half sits under the macro.

Test Plan (WIDTH=8):
- Arithmetic and overflow:
  - add a=0x7F b=0x01 -> after 1 cycle c=0x80, overflow=1, negative=1, carry_out=0.
  - sbc a=0x00 b=0x00 carry=1 -> c=0xFF, carry_out=1, overflow=0.
- cmp:
  - a=0x10 b=0x20 -> c=0xFF, carry_out=1;
  - a=b=0x33 -> c=0x00, zero=1;
  - a=0x21 b=0x20 -> c=0x01.
- Shifts:
  - shr a=0x81 b=0x03 -> out_valid 4 cycles after accept, c=0x10, carry_out=0.
  - asr a=0x80 b=0x07 -> c=0xFF, carry_out=0.
  - shl a=0xC0 b=0x00 -> latency 1, c=0xC0, carry_out=0.
- Handshake: hold out_ready=0 for 5 cycles after out_valid -> c and flags stable, in_ready=0. Then out_ready=1 -> IDLE and in_ready=1 next cycle; a second op is accepted.
- Reset mid-operation: assert rst during EXEC of a shift by 7 -> outputs immediately 0, in_ready=1, no out_valid afterwards.
- Multiply:
  - With ALU_SEQ_MUL_EN: a=0xFF b=0xFF -> after 9 cycles {c_hi,c}=0xFE01, carry_out=1.
  - Without it: the same stimulus -> c=0xFF after 1 cycle, c_hi=0.
